// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_pkg.sv
// Shared types and defaults for the gate1 data mux controller.
// Build option FIREBIRD7_DATA_MUX_READBACK_EN is consumed by the top module.
package firebird7_in_gate1_tessent_data_mux_ctrl_pkg;

    typedef enum logic [1:0] {
        FUNC    = 2'd0,
        QUIESCE = 2'd1,
        IJTAG   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH         = 19;
    localparam int DEFAULT_SETTLE_CYCLES = 4;

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_tdr.sv
// Capture/shift/update TDR; top bit is the select request.
// Capture has priority over shift, shift over update.
module firebird7_in_gate1_tessent_data_mux_tdr
    import firebird7_in_gate1_tessent_data_mux_ctrl_pkg::*;
#(
    parameter int LEN = DEFAULT_WIDTH + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sel,
    input  logic           si,
    input  logic           ce,
    input  logic           se,
    input  logic           ue,
    input  logic [LEN-1:0] capture_data,
    output logic           so,
    output logic [LEN-2:0] upd_data,
    output logic           req_sel
);

    logic [LEN-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr       <= '0;
            upd_data <= '0;
            req_sel  <= 1'b0;
        end else if (sel) begin
            if (ce) begin
                sr <= capture_data;
            end else if (se) begin
                sr <= {si, sr[LEN-1:1]};
            end else if (ue) begin
                upd_data <= sr[LEN-2:0];
                req_sel  <= sr[LEN-1];
            end
        end
    end

    assign so = sr[0];

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// IJTAG controller handing the gate1 data mux between functional and IJTAG use.
// Define FIREBIRD7_DATA_MUX_READBACK_EN to capture the live mux output.
module firebird7_in_gate1_tessent_data_mux_ctrl
    import firebird7_in_gate1_tessent_data_mux_ctrl_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_si,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    output logic             ijtag_so,
    input  logic             func_idle,
    input  logic [WIDTH-1:0] mux_data_out,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_in,
    output logic             func_hold,
    output logic             switch_busy
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be within 1..255");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] upd_data;
    logic [WIDTH-1:0] capture_src;
    logic             req_sel;

`ifdef FIREBIRD7_DATA_MUX_READBACK_EN
    assign capture_src = mux_data_out;
`else
    logic unused_readback;
    assign capture_src     = upd_data;
    assign unused_readback = ^mux_data_out;
`endif

    firebird7_in_gate1_tessent_data_mux_tdr #(
        .LEN(WIDTH + 1)
    ) u_tdr (
        .clk         (ijtag_tck),
        .rst         (ijtag_reset),
        .sel         (ijtag_sel),
        .si          (ijtag_si),
        .ce          (ijtag_ce),
        .se          (ijtag_se),
        .ue          (ijtag_ue),
        .capture_data({ijtag_select, capture_src}),
        .so          (ijtag_so),
        .upd_data    (upd_data),
        .req_sel     (req_sel)
    );

    assign ijtag_data_in = upd_data;

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            state_q <= FUNC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Abort (req_sel low) wins over func_idle while quiescing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            FUNC: begin
                if (req_sel) state_d = QUIESCE;
            end
            QUIESCE: begin
                if (!req_sel) state_d = FUNC;
                else if (func_idle) state_d = IJTAG;
            end
            IJTAG: begin
                if (!req_sel) begin
                    state_d = RELEASE;
                    cnt_d   = CNT_LOAD;
                end
            end
            RELEASE: begin
                if (cnt_q == '0) state_d = FUNC;
                else cnt_d = cnt_q - CNT_ONE;
            end
            default: state_d = FUNC;
        endcase
    end

    always_comb begin
        ijtag_select = 1'b0;
        func_hold    = 1'b0;
        switch_busy  = 1'b0;
        unique case (state_q)
            FUNC: ;
            QUIESCE: begin
                func_hold   = 1'b1;
                switch_busy = 1'b1;
            end
            IJTAG: begin
                ijtag_select = 1'b1;
                func_hold    = 1'b1;
            end
            RELEASE: begin
                func_hold   = 1'b1;
                switch_busy = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
